// File: rtl/fault_event_scheduler.sv
// Fault event scheduler: latches per-source fault reports, arbitrates them and issues
// one minor/critical pulse at a time to recovery_fsm, with escalation and hang detection.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no event outstanding; selects the next pending source
// ST_ISSUE | one cycle; minor_fault or critical_fault pulse is high
// ST_WAIT  | waiting for recovery_done while the hang timer runs
// ST_RETRY | one cycle; critical_fault re-issued for the same source
// ST_HALT  | second consecutive hang; terminal until reset
module fault_event_scheduler #(
  parameter int N_SRC          = 4,
  parameter int SRC_W          = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ESC_THRESH     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] fault_valid,
  input  logic [N_SRC-1:0] fault_crit,
  input  logic             recovery_done,
  output logic             minor_fault,
  output logic             critical_fault,
  output logic [SRC_W-1:0] active_src,
  output logic [N_SRC-1:0] pending,
  output logic             timeout_err,
  output logic             halt_req,
  output logic [7:0]       fault_total
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETRY,
    ST_HALT
  } state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] ESC_LIM  = 4'(ESC_THRESH);

  state_t           state;
  logic [N_SRC-1:0] crit_flag;
  logic [3:0]       esc_cnt [N_SRC];
  logic [SRC_W-1:0] rr_ptr;
  logic [7:0]       tmr;
  logic             retry_flag;

  logic             crit_hit;
  logic [SRC_W-1:0] crit_idx;
  logic [SRC_W-1:0] rr_idx;
  logic [SRC_W-1:0] rr_cand;
  logic [SRC_W-1:0] sel_idx;
  logic             sel_crit;
  logic             issue_now;

  // Critical sources win by lowest index; otherwise round-robin after the last RR pick.
  always_comb begin
    crit_hit = 1'b0;
    crit_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i] && crit_flag[i]) begin
        crit_hit = 1'b1;
        crit_idx = SRC_W'(i);
      end
    end
    rr_idx  = '0;
    rr_cand = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      rr_cand = SRC_W'((int'(rr_ptr) + k) % N_SRC);
      if (pending[rr_cand]) rr_idx = rr_cand;
    end
    sel_idx   = crit_hit ? crit_idx : rr_idx;
    sel_crit  = crit_hit || (esc_cnt[sel_idx] >= ESC_LIM);
    issue_now = (state == ST_IDLE) && (|pending);
  end

  // A new report on the edge that clears the source wins and restarts its severity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      crit_flag <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (fault_valid[i]) begin
          pending[i]   <= 1'b1;
          crit_flag[i] <= (issue_now && sel_idx == SRC_W'(i)) ? fault_crit[i]
                                                              : (crit_flag[i] | fault_crit[i]);
        end else if (issue_now && sel_idx == SRC_W'(i)) begin
          pending[i]   <= 1'b0;
          crit_flag[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      minor_fault    <= 1'b0;
      critical_fault <= 1'b0;
      active_src     <= '0;
      timeout_err    <= 1'b0;
      halt_req       <= 1'b0;
      fault_total    <= '0;
      rr_ptr         <= '0;
      tmr            <= '0;
      retry_flag     <= 1'b0;
      for (int i = 0; i < N_SRC; i++) esc_cnt[i] <= '0;
    end else begin
      minor_fault    <= 1'b0;
      critical_fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_now) begin
            state          <= ST_ISSUE;
            active_src     <= sel_idx;
            minor_fault    <= ~sel_crit;
            critical_fault <= sel_crit;
            if (fault_total != 8'hFF) fault_total <= fault_total + 8'd1;
            if (!crit_hit) rr_ptr <= sel_idx;
            if (sel_crit)
              esc_cnt[sel_idx] <= '0;
            else if (esc_cnt[sel_idx] != 4'hF)
              esc_cnt[sel_idx] <= esc_cnt[sel_idx] + 4'd1;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
          tmr   <= TMR_LOAD;
        end
        ST_WAIT: begin
          if (recovery_done) begin
            state      <= ST_IDLE;
            retry_flag <= 1'b0;
          end else if (tmr == 8'd0) begin
            timeout_err <= 1'b1;
            if (!retry_flag) begin
              retry_flag     <= 1'b1;
              critical_fault <= 1'b1;
              state          <= ST_RETRY;
              if (fault_total != 8'hFF) fault_total <= fault_total + 8'd1;
            end else begin
              halt_req <= 1'b1;
              state    <= ST_HALT;
            end
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        ST_RETRY: begin
          state <= ST_WAIT;
          tmr   <= TMR_LOAD;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_event_scheduler.sv
// Bench for fault_event_scheduler: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model of the scheduling rules.
module tb_fault_event_scheduler;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int TO  = 64;
  localparam int ESC = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] fault_valid;
  logic [N-1:0] fault_crit;
  logic         recovery_done;
  logic         minor_fault;
  logic         critical_fault;
  logic [W-1:0] active_src;
  logic [N-1:0] pending;
  logic         timeout_err;
  logic         halt_req;
  logic [7:0]   fault_total;

  always #5 clk = ~clk;

  fault_event_scheduler #(
    .N_SRC(N), .SRC_W(W), .TIMEOUT_CYCLES(TO), .ESC_THRESH(ESC)
  ) dut (
    .clk(clk), .reset(reset), .fault_valid(fault_valid), .fault_crit(fault_crit),
    .recovery_done(recovery_done), .minor_fault(minor_fault), .critical_fault(critical_fault),
    .active_src(active_src), .pending(pending), .timeout_err(timeout_err),
    .halt_req(halt_req), .fault_total(fault_total)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an event is either being pulsed, awaited with a deadline, or none.
  bit m_pend [N];
  bit m_crit [N];
  int m_esc  [N];
  int m_last, m_src, m_total, m_wait_left;
  bit m_minor, m_critp, m_in_issue, m_in_retry, m_retried, m_halted, m_to, m_halt;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_crit[i] = 0; m_esc[i] = 0;
    end
    m_last = 0; m_src = 0; m_total = 0; m_wait_left = -1;
    m_minor = 0; m_critp = 0; m_in_issue = 0; m_in_retry = 0;
    m_retried = 0; m_halted = 0; m_to = 0; m_halt = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] fv, input logic [N-1:0] fc,
                                     input logic done);
    int sel = -1;
    bit via_rr = 0;
    bit sev;
    bit idle;
    idle = !m_halted && !m_in_issue && !m_in_retry && (m_wait_left < 0);
    m_minor = 0;
    m_critp = 0;
    if (idle) begin
      for (int i = 0; i < N && sel < 0; i++)
        if (m_pend[i] && m_crit[i]) sel = i;
      for (int k = 1; k <= N && sel < 0; k++)
        if (m_pend[(m_last + k) % N]) begin
          sel = (m_last + k) % N;
          via_rr = 1;
        end
      if (sel >= 0) begin
        sev = m_crit[sel] || (m_esc[sel] >= ESC);
        m_minor = !sev;
        m_critp = sev;
        m_total = (m_total < 255) ? m_total + 1 : 255;
        m_esc[sel] = sev ? 0 : ((m_esc[sel] < 15) ? m_esc[sel] + 1 : 15);
        if (via_rr) m_last = sel;
        m_src = sel;
        m_in_issue = 1;
      end
    end else if (m_in_issue || m_in_retry) begin
      m_in_issue = 0;
      m_in_retry = 0;
      m_wait_left = TO;
    end else if (m_wait_left >= 0) begin
      if (done) begin
        m_wait_left = -1;
        m_retried = 0;
      end else begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_wait_left = -1;
          m_to = 1;
          if (!m_retried) begin
            m_retried = 1;
            m_in_retry = 1;
            m_critp = 1;
            m_total = (m_total < 255) ? m_total + 1 : 255;
          end else begin
            m_halt = 1;
            m_halted = 1;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (fv[i]) begin
        m_crit[i] = (sel == i) ? fc[i] : (m_crit[i] | fc[i]);
        m_pend[i] = 1;
      end else if (sel == i) begin
        m_pend[i] = 0;
        m_crit[i] = 0;
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] exp_pend;
    for (int i = 0; i < N; i++) exp_pend[i] = m_pend[i];
    check("minor_fault", minor_fault, m_minor);
    check("critical_fault", critical_fault, m_critp);
    check("active_src", active_src, m_src);
    check("pending", pending, exp_pend);
    check("timeout_err", timeout_err, m_to);
    check("halt_req", halt_req, m_halt);
    check("fault_total", fault_total, m_total);
  endtask

  task automatic cyc(input logic [N-1:0] fv, input logic [N-1:0] fc, input logic done);
    fault_valid = fv;
    fault_crit = fc;
    recovery_done = done;
    @(posedge clk);
    model_step(fv, fc, done);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_minor", minor_fault, 0);
    check("rst_crit", critical_fault, 0);
    check("rst_src", active_src, 0);
    check("rst_pending", pending, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_halt", halt_req, 0);
    check("rst_total", fault_total, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [N-1:0] rv, rc;
  logic         rd;
  int           exp_rr [3];
  bit           exp_sev [5];

  initial begin
    reset = 1'b1;
    fault_valid = '0;
    fault_crit = '0;
    recovery_done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Single minor fault, answered three cycles into WAIT
    cyc(4'b0001, 4'b0000, 0);
    cyc('0, '0, 0);
    check("t1_minor", minor_fault, 1);
    check("t1_src", active_src, 0);
    idle_cycles(2);
    cyc('0, '0, 1);
    idle_cycles(1);
    check("t1_total", fault_total, 1);

    // Critical on 3 beats minor on 1 in the same cycle
    cyc(4'b1010, 4'b1000, 0);
    cyc('0, '0, 0);
    check("t2_crit", critical_fault, 1);
    check("t2_src", active_src, 3);
    cyc('0, '0, 0);
    cyc('0, '0, 1);
    cyc('0, '0, 0);
    check("t2_minor", minor_fault, 1);
    check("t2_src2", active_src, 1);
    check("t2_pending", pending, 0);
    cyc('0, '0, 0);
    cyc('0, '0, 1);

    // Round-robin: serve source 0, then 0,1,2 pending -> 1,2,0
    cyc(4'b0001, 4'b0000, 0);
    cyc('0, '0, 0);
    cyc(4'b0111, 4'b0000, 0);
    cyc('0, '0, 1);
    exp_rr = '{1, 2, 0};
    for (int j = 0; j < 3; j++) begin
      cyc('0, '0, 0);
      check("t3_rr_minor", minor_fault, 1);
      check("t3_rr_src", active_src, exp_rr[j]);
      cyc('0, '0, 0);
      cyc('0, '0, 1);
    end

    // Escalation on source 2 from a clean counter
    do_reset();
    exp_sev = '{0, 0, 0, 1, 0};
    for (int j = 0; j < 5; j++) begin
      cyc(4'b0100, 4'b0000, 0);
      cyc('0, '0, 0);
      check("t4_esc_crit", critical_fault, exp_sev[j]);
      check("t4_esc_minor", minor_fault, !exp_sev[j]);
      cyc('0, '0, 0);
      cyc('0, '0, 1);
    end

    // Hang: first timeout retries as critical, second one halts
    do_reset();
    cyc(4'b0001, 4'b0000, 0);
    cyc('0, '0, 0);
    idle_cycles(64);
    check("t5_no_timeout_yet", timeout_err, 0);
    idle_cycles(1);
    check("t5_timeout", timeout_err, 1);
    check("t5_retry", critical_fault, 1);
    idle_cycles(64);
    check("t5_no_halt_yet", halt_req, 0);
    idle_cycles(1);
    check("t5_halt", halt_req, 1);
    for (int j = 0; j < 10; j++) cyc(4'b1111, 4'b0101, 1'(j & 1));
    check("t5_halt_silent", critical_fault | minor_fault, 0);

    // Async reset mid-WAIT with 0110 pending, then a fresh fault
    do_reset();
    cyc(4'b0001, 4'b0000, 0);
    cyc('0, '0, 0);
    cyc(4'b0110, 4'b0000, 0);
    cyc('0, '0, 0);
    check("t6_pending", pending, 4'b0110);
    do_reset();
    idle_cycles(4);
    cyc(4'b1000, 4'b0000, 0);
    cyc('0, '0, 0);
    check("t6_minor", minor_fault, 1);
    check("t6_total", fault_total, 1);
    cyc('0, '0, 0);
    cyc('0, '0, 1);

    // Random traffic, alternating answer rates so both timeouts and quick service occur
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++) begin
          rv[i] = ($urandom_range(0, 7) == 0);
          rc[i] = ($urandom_range(0, 3) == 0);
        end
        rd = (seg % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
        cyc(rv, rc, rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
